atmos_light_estimate: RTL and testbench

//   Consumes the dark-channel pixel stream from the 3x3 block-minimum stage and estimates atmospheric

---
 rtl/atmos_light_estimate.sv | 183 ++++++++++++++++++
 tb/tb_atmos_light_estimate.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmos_light_estimate.sv
// Atmospheric light estimator for haze removal.
// Tracks the brightest dark-channel pixel per frame and latches a clamped A at frame end.
// Video timing and pixel data pass through with one register of latency.
module atmos_light_estimate #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter logic [7:0]  A_INIT     = 8'd255,
    parameter logic [7:0]  A_MIN      = 8'd100,
    parameter logic [7:0]  A_MAX      = 8'd240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_href,
    input  logic       pre_frame_clken,
    input  logic [7:0] pre_img,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img,
    output logic [7:0] atmos_light,
    output logic       atmos_valid,
    output logic [9:0] max_x,
    output logic [9:0] max_y
);

    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] X_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_HEIGHT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    logic          post_vsync_q, post_href_q, post_clken_q;
    logic [7:0]    post_img_q;
    logic          vsync_d_q, href_d_q;
    logic          vsync_rise, vsync_fall, href_fall;

    logic [1:0]    state_q, state_d;
    logic [7:0]    run_max_q, run_max_d;
    logic [CW-1:0] run_x_q, run_x_d;
    logic [CW-1:0] run_y_q, run_y_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          seen_q, seen_d;
    logic [7:0]    atmos_light_q, atmos_light_d;
    logic          atmos_valid_q, atmos_valid_d;
    logic [CW-1:0] max_x_q, max_x_d;
    logic [CW-1:0] max_y_q, max_y_d;

    function automatic logic [7:0] clamp_a(input logic [7:0] v);
        if (v < A_MIN)      return A_MIN;
        else if (v > A_MAX) return A_MAX;
        else                return v;
    endfunction

    // One-cycle pass-through of timing and pixel data, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_clken_q <= 1'b0;
            post_img_q   <= 8'd0;
        end else begin
            post_vsync_q <= pre_frame_vsync;
            post_href_q  <= pre_frame_href;
            post_clken_q <= pre_frame_clken;
            post_img_q   <= pre_img;
        end
    end

    // Edge-detect history; vsync history resets high so a frame already in progress
    // at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_q <= 1'b1;
            href_d_q  <= 1'b0;
        end else begin
            vsync_d_q <= pre_frame_vsync;
            href_d_q  <= pre_frame_href;
        end
    end

    assign vsync_rise = pre_frame_vsync & ~vsync_d_q;
    assign vsync_fall = ~pre_frame_vsync & vsync_d_q;
    assign href_fall  = ~pre_frame_href & href_d_q;

    // FSM state, running max tracker, pixel counters and latched outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            run_max_q     <= 8'd0;
            run_x_q       <= '0;
            run_y_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            seen_q        <= 1'b0;
            atmos_light_q <= A_INIT;
            atmos_valid_q <= 1'b0;
            max_x_q       <= '0;
            max_y_q       <= '0;
        end else begin
            state_q       <= state_d;
            run_max_q     <= run_max_d;
            run_x_q       <= run_x_d;
            run_y_q       <= run_y_d;
            x_q           <= x_d;
            y_q           <= y_d;
            seen_q        <= seen_d;
            atmos_light_q <= atmos_light_d;
            atmos_valid_q <= atmos_valid_d;
            max_x_q       <= max_x_d;
            max_y_q       <= max_y_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        run_max_d     = run_max_q;
        run_x_d       = run_x_q;
        run_y_d       = run_y_q;
        x_d           = x_q;
        y_d           = y_q;
        seen_d        = seen_q;
        atmos_light_d = atmos_light_q;
        atmos_valid_d = 1'b0;
        max_x_d       = max_x_q;
        max_y_d       = max_y_q;

        case (state_q)
            S_IDLE: begin
                if (vsync_rise) begin
                    state_d   = S_ACTIVE;
                    run_max_d = 8'd0;
                    run_x_d   = '0;
                    run_y_d   = '0;
                    x_d       = '0;
                    y_d       = '0;
                    seen_d    = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (pre_frame_clken && pre_frame_href) begin
                    // Strict compare keeps the first occurrence on ties.
                    if (!seen_q || (pre_img > run_max_q)) begin
                        run_max_d = pre_img;
                        run_x_d   = x_q;
                        run_y_d   = y_q;
                    end
                    seen_d = 1'b1;
                    if (x_q != X_LAST) x_d = x_q + CW'(1);
                end
                if (href_fall) begin
                    x_d = '0;
                    if (y_q != Y_LAST) y_d = y_q + CW'(1);
                end
                if (vsync_fall) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (seen_q) begin
                    atmos_light_d = clamp_a(run_max_q);
                    max_x_d       = run_x_q;
                    max_y_d       = run_y_q;
                    atmos_valid_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign post_frame_vsync = post_vsync_q;
    assign post_frame_href  = post_href_q;
    assign post_frame_clken = post_clken_q;
    assign post_img         = post_img_q;
    assign atmos_light      = atmos_light_q;
    assign atmos_valid      = atmos_valid_q;
    assign max_x            = max_x_q;
    assign max_y            = max_y_q;

endmodule

// File: tb/tb_atmos_light_estimate.sv
// Directed bench for atmos_light_estimate using 4x3 frames.
module tb_atmos_light_estimate;

    logic       clk;
    logic       rst_n;
    logic       pre_frame_vsync;
    logic       pre_frame_href;
    logic       pre_frame_clken;
    logic [7:0] pre_img;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img;
    logic [7:0] atmos_light;
    logic       atmos_valid;
    logic [9:0] max_x;
    logic [9:0] max_y;

    int total = 0;
    int bad   = 0;

    logic [7:0] pix [0:11];
    int pulses;
    int first_pulse;
    int hold_bad;

    atmos_light_estimate dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_href   (pre_frame_href),
        .pre_frame_clken  (pre_frame_clken),
        .pre_img          (pre_img),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img         (post_img),
        .atmos_light      (atmos_light),
        .atmos_valid      (atmos_valid),
        .max_x            (max_x),
        .max_y            (max_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input bit check_hold, input logic [7:0] exp_hold);
        @(posedge clk);
        #1;
        if (check_hold && ((atmos_light !== exp_hold) || (atmos_valid !== 1'b0)))
            hold_bad++;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 12; i++) pix[i] = v;
    endtask

    // Drive one 4x3 frame, then watch a bounded window for atmos_valid pulses.
    // rst_row >= 0 pulses reset just before that row while vsync stays high.
    task automatic run_frame(input bit with_clken, input int rst_row,
                             input bit check_hold, input logic [7:0] exp_hold);
        hold_bad    = 0;
        pulses      = 0;
        first_pulse = -1;
        pre_frame_vsync = 1'b1;
        tick(check_hold, exp_hold);
        tick(check_hold, exp_hold);
        for (int r = 0; r < 3; r++) begin
            if (r == rst_row) begin
                rst_n = 1'b0;
                #2;
                total++;
                if (atmos_light !== 8'd255) begin
                    bad++;
                    $display("FAIL midrst_a: got %0d want 255", atmos_light);
                end
                total++;
                if (atmos_valid !== 1'b0 || max_x !== 10'd0 || max_y !== 10'd0) begin
                    bad++;
                    $display("FAIL midrst_misc: valid=%0b x=%0d y=%0d want 0 0 0",
                             atmos_valid, max_x, max_y);
                end
                tick(1'b0, 8'd0);
                rst_n = 1'b1;
                tick(1'b0, 8'd0);
            end
            pre_frame_href = 1'b1;
            for (int c = 0; c < 4; c++) begin
                pre_frame_clken = with_clken;
                pre_img         = pix[r*4 + c];
                tick(check_hold, exp_hold);
            end
            pre_frame_clken = 1'b0;
            pre_frame_href  = 1'b0;
            pre_img         = 8'd0;
            tick(check_hold, exp_hold);
            tick(check_hold, exp_hold);
        end
        pre_frame_vsync = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 8'd0);
            if (atmos_valid === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
    endtask

    task automatic check_update(input string name, input logic [7:0] ea,
                                input logic [9:0] ex, input logic [9:0] ey);
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL %s_pulses: got %0d want 1", name, pulses);
        end
        total++;
        if (atmos_light !== ea) begin
            bad++;
            $display("FAIL %s_a: got %0d want %0d", name, atmos_light, ea);
        end
        total++;
        if (max_x !== ex || max_y !== ey) begin
            bad++;
            $display("FAIL %s_xy: got (%0d,%0d) want (%0d,%0d)", name, max_x, max_y, ex, ey);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pre_frame_vsync = 1'b0;
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b0;
        pre_img         = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (atmos_light !== 8'd255 || atmos_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: a=%0d v=%0b want 255 0", atmos_light, atmos_valid);
        end
        total++;
        if (max_x !== 10'd0 || max_y !== 10'd0) begin
            bad++;
            $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", max_x, max_y);
        end
        total++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img} !== 11'd0) begin
            bad++;
            $display("FAIL reset_post: got %b want 0",
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img});
        end
        rst_n = 1'b1;
        tick(1'b0, 8'd0);
        tick(1'b0, 8'd0);
    endtask

    task automatic test_single_max;
        fill(8'd50);
        pix[1*4 + 2] = 8'd200;
        run_frame(1'b1, -1, 1'b1, 8'd255);
        check_update("single", 8'd200, 10'd2, 10'd1);
        total++;
        if (first_pulse !== 2) begin
            bad++;
            $display("FAIL single_latency: got %0d want 2", first_pulse);
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL single_hold: got %0d changes want 0", hold_bad);
        end
    endtask

    task automatic test_clamp;
        fill(8'd250);
        run_frame(1'b1, -1, 1'b0, 8'd0);
        check_update("clamp_hi", 8'd240, 10'd0, 10'd0);
        fill(8'd20);
        run_frame(1'b1, -1, 1'b0, 8'd0);
        check_update("clamp_lo", 8'd100, 10'd0, 10'd0);
    endtask

    task automatic test_tie_and_hold;
        fill(8'd10);
        pix[0*4 + 1] = 8'd180;
        pix[2*4 + 3] = 8'd180;
        run_frame(1'b1, -1, 1'b0, 8'd0);
        check_update("tie", 8'd180, 10'd1, 10'd0);
        fill(8'd30);
        pix[2*4 + 1] = 8'd150;
        run_frame(1'b1, -1, 1'b1, 8'd180);
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL tie_hold: got %0d changes want 0", hold_bad);
        end
        check_update("after_tie", 8'd150, 10'd1, 10'd2);
    endtask

    task automatic test_no_clken;
        fill(8'd230);
        run_frame(1'b0, -1, 1'b1, 8'd150);
        total++;
        if (pulses !== 0 || atmos_light !== 8'd150) begin
            bad++;
            $display("FAIL noclken: pulses=%0d a=%0d want 0 150", pulses, atmos_light);
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL noclken_hold: got %0d changes want 0", hold_bad);
        end
    endtask

    task automatic test_mid_reset;
        fill(8'd220);
        run_frame(1'b1, 1, 1'b0, 8'd0);
        total++;
        if (pulses !== 0 || atmos_light !== 8'd255) begin
            bad++;
            $display("FAIL midrst_ignored: pulses=%0d a=%0d want 0 255", pulses, atmos_light);
        end
        fill(8'd120);
        pix[2*4 + 0] = 8'd121;
        run_frame(1'b1, -1, 1'b0, 8'd0);
        check_update("postrst", 8'd121, 10'd0, 10'd2);
    endtask

    task automatic test_passthrough;
        logic [10:0] prev;
        logic [10:0] now;
        prev = {pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img};
        for (int i = 0; i < 40; i++) begin
            now = 11'($urandom);
            pre_frame_vsync = now[10];
            pre_frame_href  = now[9];
            pre_frame_clken = now[8];
            pre_img         = now[7:0];
            @(posedge clk);
            #1;
            total++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img} !== now) begin
                bad++;
                $display("FAIL pass_%0d: got %h want %h (prev %h)", i,
                         {post_frame_vsync, post_frame_href, post_frame_clken, post_img}, now, prev);
            end
            prev = now;
        end
    endtask

    initial begin
        test_reset();
        test_single_max();
        test_clamp();
        test_tie_and_hold();
        test_no_clken();
        test_mid_reset();
        test_passthrough();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
